// File: rtl/cu_pkg.sv
// Shared definitions for the control-unit sequencer and its one-hot decoder:
// state codes, opcode encoding and memory-read state classification.
package cu_pkg;

  localparam int unsigned FETCH1     = 0;
  localparam int unsigned FETCH2     = 1;
  localparam int unsigned FETCH3     = 2;
  localparam int unsigned ADD1       = 3;
  localparam int unsigned ADD2       = 4;
  localparam int unsigned AND1       = 5;
  localparam int unsigned AND2       = 6;
  localparam int unsigned JMP1       = 7;
  localparam int unsigned INC1       = 8;
  localparam int unsigned NUM_STATES = 9;

  typedef enum logic [1:0] {OP_ADD, OP_AND, OP_JMP, OP_INC} op_e;

  // States that read memory and must wait for mem_ready.
  function automatic logic is_mem_state(input int unsigned code);
    return (code == FETCH2) || (code == ADD1) || (code == AND1);
  endfunction

endpackage

// File: rtl/cu_next_state.sv
// Combinational next-code logic: fetch walk, opcode dispatch, memory stall,
// run gating in FETCH1 and recovery from unused codes.
module cu_next_state
  import cu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] code_i,
  input  logic         run_i,
  input  logic         mem_ready_i,
  input  logic         adv_en_i,
  input  op_e          opcode_i,
  output logic [N-1:0] code_o,
  output logic         retire_o
);

  logic stalled;

  assign stalled = is_mem_state(32'(code_i)) && !mem_ready_i;

  // NOTE: every output gets a default before any branch so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    code_o   = code_i;
    retire_o = 1'b0;
    if (32'(code_i) >= NUM_STATES) begin
      // Unused codes recover unconditionally and never count as a retirement.
      code_o = '0;
    end else if (adv_en_i && !stalled) begin
      case (32'(code_i))
        FETCH1: if (run_i) code_o = N'(FETCH2);
        FETCH2: code_o = N'(FETCH3);
        FETCH3: begin
          case (opcode_i)
            OP_ADD: code_o = N'(ADD1);
            OP_AND: code_o = N'(AND1);
            OP_JMP: code_o = N'(JMP1);
            OP_INC: code_o = N'(INC1);
            default: code_o = N'(ADD1);
          endcase
        end
        ADD1: code_o = N'(ADD2);
        AND1: code_o = N'(AND2);
        ADD2, AND2, JMP1, INC1: begin
          code_o   = N'(FETCH1);
          retire_o = 1'b1;
        end
        default: code_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/cu_sequence_counter.sv
// Control-unit state counter feeding the one-hot decoder, with retire status.
// Optional single-step control is enabled by defining CU_SINGLE_STEP_EN.
module cu_sequence_counter
  import cu_pkg::*;
#(
  parameter int N      = 4,  // must be at least 4 to hold INC1
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [1:0]        ir_opcode,
`ifdef CU_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step_req,
`endif
  output logic [N-1:0]      counter_value,
  output logic              instr_done,
  output logic              halted,
  output logic [ICNT_W-1:0] instr_count
);

  logic [N-1:0]      state_q, state_d;
  logic              done_q, done_d;
  logic              halted_q, halted_d;
  logic [ICNT_W-1:0] count_q, count_d;
  logic              adv_en;
  logic              retire;

`ifdef CU_SINGLE_STEP_EN
  assign adv_en = !step_mode || step_req;
`else
  assign adv_en = 1'b1;
`endif

  cu_next_state #(.N(N)) u_next_state (
    .code_i      (state_q),
    .run_i       (run),
    .mem_ready_i (mem_ready),
    .adv_en_i    (adv_en),
    .opcode_i    (op_e'(ir_opcode)),
    .code_o      (state_d),
    .retire_o    (retire)
  );

  // halted tracks run only while parked in FETCH1; elsewhere it holds.
  assign halted_d = (state_q == N'(FETCH1)) ? !run : halted_q;
  assign done_d   = retire;
  assign count_d  = count_q + ICNT_W'(retire);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      done_q   <= 1'b0;
      halted_q <= 1'b1;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign counter_value = state_q;
  assign instr_done    = done_q;
  assign halted        = halted_q;
  assign instr_count   = count_q;

endmodule
